// File: rtl/serial_master_port.sv
// Master-side serial bus port: takes a parallel command, requests the bus,
// shifts the frame out MSB-first and collects the read response (split-aware).
module serial_master_port #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              ready_o,
    output logic              done_o,
    output logic              err_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              req_o,
    input  logic              gnt_i,
    output logic              frame_o,
    output logic              sdata_o,
    output logic              svalid_o,
    input  logic              sdata_i,
    input  logic              svalid_i,
    input  logic              split_i
);

    localparam int FW = 1 + ADDR_W + DATA_W;
    localparam int CW = $clog2(FW + 1);
    localparam int RW = $clog2(DATA_W + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, REQ, SEND, RESP, SPLIT, DONE
    } state_t;

    state_t            state_q, state_d;
    logic              abort;
    logic              we_q;
    logic              err_q;
    logic [FW-1:0]     shreg;
    logic [CW-1:0]     bit_cnt;
    logic [CW-1:0]     last_bit;
    logic [RW-1:0]     rx_cnt;
    logic [DATA_W-1:0] rx_q;
    logic [TW-1:0]     to_cnt;
    logic              in_rx;
    logic              rx_last;
    logic              to_hit;

    assign last_bit = we_q ? CW'(FW - 1) : CW'(ADDR_W);
    assign in_rx    = (state_q == RESP) || (state_q == SPLIT);
    assign rx_last  = (rx_cnt == RW'(DATA_W - 1));
    assign to_hit   = (to_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        abort   = 1'b0;
        unique case (state_q)
            IDLE: if (start_i) state_d = REQ;
            REQ:  if (gnt_i) state_d = SEND;
            SEND: begin
                if (!gnt_i) begin
                    state_d = DONE;
                    abort   = 1'b1;
                end else if (bit_cnt == last_bit) begin
                    state_d = we_q ? DONE : RESP;
                end
            end
            RESP: begin
                if (!gnt_i) begin
                    state_d = DONE;
                    abort   = 1'b1;
                end else if (svalid_i) begin
                    if (rx_last) state_d = DONE;
                end else if (split_i) begin
                    state_d = SPLIT;
                end else if (to_hit) begin
                    state_d = DONE;
                    abort   = 1'b1;
                end
            end
            SPLIT: begin
                if (svalid_i) begin
                    state_d = rx_last ? DONE : RESP;
                end else if (to_hit) begin
                    state_d = DONE;
                    abort   = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            shreg   <= '0;
            bit_cnt <= '0;
            rx_cnt  <= '0;
            rx_q    <= '0;
            to_cnt  <= '0;
        end else begin
            if (state_q == IDLE && start_i) begin
                we_q   <= we_i;
                shreg  <= {we_i, addr_i, wdata_i};
                rx_cnt <= '0;
                rx_q   <= '0;
            end else if (state_q == SEND) begin
                shreg <= {shreg[FW-2:0], 1'b0};
            end
            bit_cnt <= (state_q == SEND) ? bit_cnt + 1'b1 : '0;
            if (in_rx && svalid_i) begin
                rx_q   <= {rx_q[DATA_W-2:0], sdata_i};
                rx_cnt <= rx_cnt + 1'b1;
            end
            // cleared outside RESP/SPLIT, on each bit, and when entering SPLIT
            if (in_rx && !svalid_i && !(state_q == RESP && split_i))
                to_cnt <= to_cnt + 1'b1;
            else
                to_cnt <= '0;
            if (state_d == DONE) err_q <= abort;
        end
    end

    always_comb begin
        ready_o  = 1'b0;
        done_o   = 1'b0;
        err_o    = 1'b0;
        rdata_o  = '0;
        req_o    = 1'b0;
        frame_o  = 1'b0;
        sdata_o  = 1'b0;
        svalid_o = 1'b0;
        unique case (state_q)
            IDLE: ready_o = 1'b1;
            REQ:  req_o = 1'b1;
            SEND: begin
                req_o    = 1'b1;
                frame_o  = 1'b1;
                svalid_o = 1'b1;
                sdata_o  = shreg[FW-1];
            end
            RESP: begin
                req_o   = 1'b1;
                frame_o = 1'b1;
            end
            SPLIT: req_o = 1'b1;
            DONE: begin
                done_o  = 1'b1;
                err_o   = err_q;
                rdata_o = err_q ? '0 : rx_q;
            end
            default: ready_o = 1'b0;
        endcase
    end

endmodule

// File: doc/serial_master_port.md
# serial_master_port

Master-side port of the serial bus; sits directly upstream of `serial_arbiter`. It accepts a parallel read/write command from a local master, requests the bus, and on grant serializes the command frame MSB-first. It drives the arbiter's frame-active input for the duration of the frame, and for reads collects the serial response, including responses delayed by a slave split. One instance per master; `req_o`/`frame_o` of instance k feed `req_i[k]`/`frame_active_i` of the arbiter, and `gnt_o[k]` returns on `gnt_i`.

## Interface
- ADDR_W, 16, address width in bits
- DATA_W, 8, data width in bits
- TIMEOUT, 256, max idle cycles awaiting a response bit before error (≥2)

- clk_i  in  1  single clock, all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  command strobe, accepted only when ready_o=1
- we_i  in  1  1=write, 0=read; sampled with start_i
- addr_i  in  ADDR_W  address; sampled with start_i
- wdata_i  in  DATA_W  write data; sampled with start_i
- ready_o  out  1  port idle, command may be issued
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  valid with done_o; 1 = timeout or grant lost
- rdata_o  out  DATA_W  read data, valid with done_o (0 on write/error)
- req_o  out  1  bus request to arbiter
- gnt_i  in  1  grant from arbiter
- frame_o  out  1  frame active, to arbiter
- sdata_o  out  1  serial bit to bus
- svalid_o  out  1  sdata_o valid
- sdata_i  in  1  serial response bit from slave
- svalid_i  in  1  sdata_i valid
- split_i  in  1  slave split indication (one-cycle pulse)

## Operation
- States: IDLE, REQ, SEND, RESP, SPLIT, DONE.
- IDLE: ready_o=1. start_i=1 → latch we/addr/wdata, go to REQ.
- REQ: req_o=1. gnt_i=1 → SEND.
- SEND: req_o=1, frame_o=1, svalid_o=1. Frame is we bit, then addr[ADDR_W-1:0] MSB first, then for writes only wdata[DATA_W-1:0] MSB first, one bit per cycle. A bit counter wraps to 0 on each state entry. After the last bit: write → DONE, read → RESP.
- gnt_i=0 in SEND/RESP → abort to DONE with err_o=1.
- RESP: req_o=1, frame_o=1, svalid_o=0. Each cycle with svalid_i=1 shifts sdata_i into rdata LSB (MSB arrives first). After DATA_W bits → DONE. split_i=1 (svalid_i=0) → SPLIT.
- SPLIT: req_o=1, frame_o=0. The received-bit count and partial data are preserved. svalid_i=1 → capture the bit and return to RESP. gnt_i is not checked in SPLIT.
- Timeout: the counter clears on RESP/SPLIT entry and on every svalid_i=1, and increments otherwise. At TIMEOUT-1 → DONE with err_o=1, rdata_o=0.
- DONE: done_o=1 for one cycle; req_o=0, frame_o=0 → IDLE.
- split_i and svalid_i asserted in the same RESP cycle: the bit is captured and split_i is ignored.
- split_i outside RESP: ignored. start_i outside IDLE: ignored.

## Timing
- Reset (rst_i=1 at an edge): state IDLE. Outputs: ready_o=1; done_o, err_o, req_o, frame_o, sdata_o, svalid_o = 0; rdata_o=0; counters=0. Reset mid-frame drops req_o/frame_o the next cycle with no done_o.
- All outputs are registered or decoded from the state register only; no combinational input→output paths.
- Write latency with immediate grant: start_i sampled at edge E0, REQ after E0, SEND after E1. The frame occupies 1+ADDR_W+DATA_W cycles (25 at defaults). done_o is high in the cycle after edge E26.
- Read with immediate grant: SEND lasts 1+ADDR_W cycles (17), then RESP. done_o follows one cycle after the edge that samples the DATA_W-th response bit.
- ready_o returns to 1 the cycle after done_o. Back-to-back commands are possible with one idle cycle between frames.

## Test plan
- Reset: hold rst_i 3 cycles mid-SEND → next cycle req_o=0, frame_o=0, ready_o=1, done_o never pulses.
- Write, gnt_i tied 1, addr=0xA5C3, wdata=0x3C → sdata_o stream 1,1010010111000011,00111100; frame_o high 25 cycles; done_o=1, err_o=0 at cycle 27.
- Read, addr=0x0010. After the frame, slave returns 0x96 with 2-cycle gaps between bits → rdata_o=0x96 with done_o, err_o=0, frame_o high throughout RESP.
- Delayed grant: gnt_i held 0 for 10 cycles → req_o=1, frame_o=0, svalid_o=0 throughout. Frame starts on the cycle after gnt_i rises.
- Split: read, 3 bits received, then split_i pulse → frame_o=0, req_o=1. Remaining 5 bits arrive 40 cycles later → rdata correct, err_o=0.
- Timeout: read with no response → done_o=1, err_o=1, rdata_o=0 after TIMEOUT cycles. Separately, dropping gnt_i mid-SEND → done_o with err_o=1 the next cycle.
